keypad_scan_ctrl: RTL
=====================

// Module: keypad_scan_ctrl
// PURPOSE
//   Sequences a 4x4 matrix keypad: rotates an active-low row strobe, detects a
//   press on the synchronised columns, freezes the scan, debounces, confirms a
//   single key, then emits one registered hex key code with a 1-cycle valid
//   strobe. Waits for a debounced release before scanning again. Feeds the
//   two-digit display/shift logic downstream.
// PARAMETERS
//   SCAN_DIV        1000     clk cycles each row is driven (dwell), >= 4
//   DEBOUNCE_CYCLES 50000    stable cycles needed for press and for release
//   REPEAT_CYCLES   500000   auto-repeat period (KEYPAD_AUTOREPEAT_EN only)
// PORTS
//   clk        in   1  system clock
//   reset      in   1  asynchronous, active-high
//   col_n      in   4  raw keypad columns, active-low (pulled up), asynchronous
//   row_n      out  4  row strobe, active-low one-hot
//   key_code   out  4  hex value of last accepted key, held until next accept
//   key_valid  out  1  1-cycle pulse when key_code is updated
//   key_held   out  1  high while an accepted key remains pressed
// BEHAVIOUR
//   Reset: state SCAN, row index 0 (row_n=4'b1110), all counters 0,
//     key_code=4'h0, key_valid=0, key_held=0, synchroniser flops = 4'b1111.
//   col_n passes through a 2-flop synchroniser -> col_s (2-cycle latency).
//   States (enum in package): SCAN, DEBOUNCE, CONFIRM, EMIT, HOLD, RELEASE.
//   SCAN: dwell counter counts 0..SCAN_DIV-1; on last dwell cycle sample col_s.
//     Any col_s bit low -> latch row index and col_s, go DEBOUNCE, row frozen.
//     Else row index increments mod 4 (3 -> 0 wrap), dwell counter clears.
//     Sampling only on last dwell cycle guarantees synchroniser has settled.
//   DEBOUNCE: counter runs while col_s == latched pattern; any mismatch -> SCAN
//     (row index advances as normal). Reaching DEBOUNCE_CYCLES -> CONFIRM.
//   CONFIRM (1 cycle): exactly one col_s bit low -> EMIT; zero or >1 low (ghost/
//     multi-key) -> SCAN, no output.
//   EMIT (1 cycle): key_code <= KEYMAP[row][col]; key_valid=1 this cycle only;
//     -> HOLD. key_held rises same cycle as key_valid.
//   HOLD: stays while the latched column is low. Column goes high -> RELEASE.
//   RELEASE: counter runs while all col_s high; any low -> back to HOLD,
//     counter clears. Reaching DEBOUNCE_CYCLES -> SCAN, key_held=0,
//     row index advances.
//   key_code/key_valid/key_held registered; key_valid never high 2 cycles running.
//   Second key pressed during HOLD/RELEASE is ignored (no output).
//   Counter widths $clog2(param+1); counters saturate, never wrap.
//   Reset mid-operation: immediate return to reset values; no key_valid pulse.
// CONFIGURATION
//   KEYPAD_AUTOREPEAT_EN defined: in HOLD a repeat counter runs; at
//     REPEAT_CYCLES it pulses key_valid (same key_code) and restarts. Cleared
//     on entering HOLD or RELEASE.
//   Undefined: exactly one key_valid per physical press; no repeat counter.
// STRUCTURE
//   keypad_pkg: state enum keypad_state_t, KEYMAP[4][4] constant
//     (rows: 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D), ROW_IDLE = 4'b1111.
//   Sub-module sync_2ff (#(W=4)): 2-flop synchroniser, async reset to all-1s.
//   Top holds FSM, dwell/debounce/repeat counters and output registers.
// TESTING  (bench params SCAN_DIV=4, DEBOUNCE_CYCLES=8, REPEAT_CYCLES=20)
//   No press, 40 cycles after reset -> row_n cycles 1110,1101,1011,0111,1110
//     every 4 cycles; key_valid never high.
//   Press row1/col2 steady (col_n=4'b1011 when row_n=4'b1101) -> one key_valid,
//     key_code=4'h6, key_held=1, row_n frozen at 1101 until release.
//   Press lasting 3 cycles then bouncing -> DEBOUNCE aborts, no key_valid,
//     scan resumes at next row.
//   Row0 col0+col1 together (col_n=4'b1100) -> CONFIRM rejects, no key_valid.
//   Release with 2-cycle bounce then stable high -> key_held drops 8 cycles
//     after last bounce; next press of row3/col1 yields key_code=4'h0.
//   KEYPAD_AUTOREPEAT_EN, hold key '9' 70 cycles -> key_valid at accept then
//     every 20 cycles, key_code=4'h9; without macro exactly one pulse.
//   reset asserted in DEBOUNCE -> row_n=1110, outputs 0 next edge, no pulse.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: state encoding,
// the key legend and column/row helpers.
package keypad_pkg;

   typedef enum logic [2:0] {
      SCAN,
      DEBOUNCE,
      CONFIRM,
      EMIT,
      HOLD,
      RELEASE
   } keypad_state_t;

   // All lines released (active-low bus with nothing driven low)
   localparam logic [3:0] ROW_IDLE = 4'b1111;

   // Legend indexed [row][col]
   localparam logic [3:0] KEYMAP [4][4] = '{
      '{4'h1, 4'h2, 4'h3, 4'hA},
      '{4'h4, 4'h5, 4'h6, 4'hB},
      '{4'h7, 4'h8, 4'h9, 4'hC},
      '{4'hE, 4'h0, 4'hF, 4'hD}
   };

   // Index of the lowest column that is pulled low
   function automatic logic [1:0] col_index(input logic [3:0] col_n);
      if (!col_n[0])      return 2'd0;
      else if (!col_n[1]) return 2'd1;
      else if (!col_n[2]) return 2'd2;
      else                return 2'd3;
   endfunction

   // Active-low one-hot strobe for a row index
   function automatic logic [3:0] row_strobe(input logic [1:0] row);
      return ~(4'b0001 << row);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs; resets to all-ones so an
// idle pulled-up bus reads released.
module sync_2ff #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= '1;
         sync_q <= '1;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: rotates the row strobe, debounces press/release and emits
// one registered key code per press. Define KEYPAD_AUTOREPEAT_EN for auto-repeat.
module keypad_scan_ctrl
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV        = 1000,
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned REPEAT_CYCLES   = 500000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] col_n_i,
   output logic [3:0] row_n_o,
   output logic [3:0] key_code_o,
   output logic       key_valid_o,
   output logic       key_held_o
);

   localparam int unsigned DW = $clog2(SCAN_DIV + 1);
   localparam int unsigned BW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CYCLES - 1);

   if (SCAN_DIV < 4) begin : g_bad_scan_div
      $error("SCAN_DIV must be at least 4");
   end
   if (DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_cycles
      $error("DEBOUNCE_CYCLES and REPEAT_CYCLES must be at least 1");
   end

   logic [3:0]    col_s;
   keypad_state_t state_q, state_d;
   logic [1:0]    row_q, row_d;
   logic [3:0]    row_n_q, row_n_d;
   logic [3:0]    col_lat_q, col_lat_d;
   logic [DW-1:0] dwell_q, dwell_d;
   logic [BW-1:0] deb_q, deb_d;
   logic [3:0]    key_code_q, key_code_d;
   logic          key_valid_q, key_valid_d;
   logic          key_held_q, key_held_d;
   logic          advance;
   logic [1:0]    lat_col;
`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int unsigned RW = $clog2(REPEAT_CYCLES + 1);
   localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
   logic [RW-1:0] rep_q, rep_d;
`endif

   sync_2ff #(.W(4)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d_i   (col_n_i),
      .q_o   (col_s)
   );

   assign lat_col = col_index(col_lat_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= SCAN;
         row_q       <= 2'd0;
         row_n_q     <= 4'b1110;
         col_lat_q   <= ROW_IDLE;
         dwell_q     <= '0;
         deb_q       <= '0;
         key_code_q  <= 4'h0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
         rep_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         row_n_q     <= row_n_d;
         col_lat_q   <= col_lat_d;
         dwell_q     <= dwell_d;
         deb_q       <= deb_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         key_held_q  <= key_held_d;
`ifdef KEYPAD_AUTOREPEAT_EN
         rep_q       <= rep_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      row_d       = row_q;
      col_lat_d   = col_lat_q;
      dwell_d     = dwell_q;
      deb_d       = deb_q;
      key_code_d  = key_code_q;
      key_valid_d = 1'b0;
      key_held_d  = key_held_q;
      advance     = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_d       = rep_q;
`endif

      unique case (state_q)
         // Columns are only trusted on the last dwell cycle, once the synchroniser has settled
         SCAN: begin
            if (dwell_q >= DWELL_LAST) begin
               if (col_s != ROW_IDLE) begin
                  col_lat_d = col_s;
                  deb_d     = '0;
                  dwell_d   = '0;
                  state_d   = DEBOUNCE;
               end else begin
                  advance = 1'b1;
               end
            end else begin
               dwell_d = dwell_q + DW'(1);
            end
         end
         DEBOUNCE: begin
            if (col_s != col_lat_q) begin
               state_d = SCAN;
               advance = 1'b1;
            end else if (deb_q >= DEB_LAST) begin
               deb_d   = '0;
               state_d = CONFIRM;
            end else begin
               deb_d = deb_q + BW'(1);
            end
         end
         // Reject ghosting / multi-key patterns
         CONFIRM: begin
            if ($countones(~col_s) == 1) begin
               col_lat_d = col_s;
               state_d   = EMIT;
            end else begin
               state_d = SCAN;
               advance = 1'b1;
            end
         end
         EMIT: begin
            key_code_d  = KEYMAP[row_q][lat_col];
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
            state_d     = HOLD;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_d       = '0;
`endif
         end
         HOLD: begin
            if (col_s[lat_col]) begin
               deb_d   = '0;
               state_d = RELEASE;
`ifdef KEYPAD_AUTOREPEAT_EN
               rep_d   = '0;
            end else if (rep_q >= REP_LAST) begin
               key_valid_d = 1'b1;
               rep_d       = '0;
            end else begin
               rep_d = rep_q + RW'(1);
`endif
            end
         end
         RELEASE: begin
            if (col_s != ROW_IDLE) begin
               deb_d   = '0;
               state_d = HOLD;
`ifdef KEYPAD_AUTOREPEAT_EN
               rep_d   = '0;
`endif
            end else if (deb_q >= DEB_LAST) begin
               deb_d      = '0;
               key_held_d = 1'b0;
               state_d    = SCAN;
               advance    = 1'b1;
            end else begin
               deb_d = deb_q + BW'(1);
            end
         end
         default: begin
            state_d = SCAN;
         end
      endcase

      if (advance) begin
         row_d   = row_q + 2'd1;
         dwell_d = '0;
      end
      row_n_d = row_strobe(row_d);
   end

   assign row_n_o     = row_n_q;
   assign key_code_o  = key_code_q;
   assign key_valid_o = key_valid_q;
   assign key_held_o  = key_held_q;

endmodule
